puf_resp_capture: RTL and testbench

- Consumer side of the PUF select FSM. Watches `puf1_counter` and `puf2_counter`.
- Each counter increment marks a completed challenge. On that event, the block captures the matching PUF response as a record {source, challenge, response}.
- Records are buffered in a FIFO and streamed out over a valid/ready interface to the readout path (UART/LED logic).
- Signals `done` once the FSM is in HALT and every record has been drained.

---
 rtl/puf_pkg.sv | 33 +++
 rtl/puf_resp_capture_fifo.sv | 59 +++++
 rtl/puf_resp_capture.sv | 156 +++++++++++++++
 tb/tb_puf_resp_capture.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared types for the PUF select FSM and the response capture block.
//   state_t     : present state of the PUF select FSM (START/PUF1/PUF2/HALT)
//   rec_t       : captured record {src, challenge, response} at default width
//   cap_state_t : completion tracker states of the capture block
// -----------------------------------------------------------------------------
package puf_pkg;

   localparam int CH_W       = 8;
   localparam int RESP_W_DEF = 8;

   typedef enum logic [1:0] {
      START = 2'd0,
      PUF1  = 2'd1,
      PUF2  = 2'd2,
      HALT  = 2'd3
   } state_t;

   // src: 0 = PUF1, 1 = PUF2. Packed MSB-first so it matches rec_data.
   typedef struct packed {
      logic                  src;
      logic [CH_W-1:0]       ch;
      logic [RESP_W_DEF-1:0] resp;
   } rec_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/puf_resp_capture_fifo.sv
// -----------------------------------------------------------------------------
// puf_rec_fifo
// Synchronous show-ahead FIFO for capture records.
//   clk, rst_n : clock / async active-low reset
//   push,wdata : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   rdata      : head entry, forced to 0 when empty
//   full,empty : occupancy flags
// -----------------------------------------------------------------------------
module puf_rec_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         wr_en, rd_en;

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      rd_en = pop && !empty;
      // A full FIFO still takes a write when the head leaves this cycle.
      wr_en = push && (!full || rd_en);
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: it is only visible through rdata when non-empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/puf_resp_capture.sv
// -----------------------------------------------------------------------------
// puf_resp_capture
// Watches the PUF select FSM challenge counters; every counter change captures
// a {src, challenge, response} record into a FIFO streamed out via valid/ready.
//   clk, rst_n       : clock / async active-low reset
//   ps               : PUF select FSM present state
//   puf1/2_counter   : challenge counters from the FSM
//   puf1/2_resp      : live PUF responses
//   rec_valid/ready  : record stream handshake
//   rec_data         : {src, challenge[7:0], resp}, 0 when nothing queued
//   rec_count        : records accepted since reset, saturating at 1023
//   overflow         : sticky, a record was dropped
//   done             : FSM halted and every record drained
// -----------------------------------------------------------------------------
module puf_resp_capture
   import puf_pkg::*;
#(
   parameter int RESP_W = RESP_W_DEF,
   parameter int DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  state_t                 ps,
   input  logic [CH_W-1:0]        puf1_counter,
   input  logic [CH_W-1:0]        puf2_counter,
   input  logic [RESP_W-1:0]      puf1_resp,
   input  logic [RESP_W-1:0]      puf2_resp,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [CH_W+RESP_W:0]   rec_data,
   output logic [9:0]             rec_count,
   output logic                   overflow,
   output logic                   done
);

   localparam int REC_W = 1 + CH_W + RESP_W;

   // Counter and response history; the delayed response is the one present
   // on the edge where the counter moved.
   logic [CH_W-1:0]   prev1_q, prev1_d, prev2_q, prev2_d;
   logic [RESP_W-1:0] resp1_q, resp1_d, resp2_q, resp2_d;

   logic              pend_vld_q, pend_vld_d;
   logic [REC_W-1:0]  pend_rec_q, pend_rec_d;
   logic              ovf_q, ovf_d;
   logic [9:0]        cnt_q, cnt_d;
   cap_state_t        state_q, state_d;
   logic              done_q, done_d;

   logic              ev1, ev2;
   logic [REC_W-1:0]  cand1, cand2, push_rec;
   logic              push_req, push_ok, pop, drop;
   logic              fifo_full, fifo_empty;

   always_comb begin
      prev1_d = puf1_counter;
      prev2_d = puf2_counter;
      resp1_d = puf1_resp;
      resp2_d = puf2_resp;

      ev1   = (puf1_counter != prev1_q);
      ev2   = (puf2_counter != prev2_q);
      cand1 = {1'b0, prev1_q, resp1_q};
      cand2 = {1'b1, prev2_q, resp2_q};
      pop   = !fifo_empty && rec_ready;

      // One push per cycle, priority pending > ev1 > ev2. The losers park in
      // the single pending slot; a third contender has nowhere to go.
      push_req   = 1'b0;
      push_rec   = '0;
      drop       = 1'b0;
      pend_vld_d = pend_vld_q;
      pend_rec_d = pend_rec_q;
      if (pend_vld_q) begin
         push_req   = 1'b1;
         push_rec   = pend_rec_q;
         pend_vld_d = ev1 || ev2;
         pend_rec_d = ev1 ? cand1 : cand2;
         drop       = ev1 && ev2;
      end else if (ev1) begin
         push_req   = 1'b1;
         push_rec   = cand1;
         pend_vld_d = ev2;
         pend_rec_d = cand2;
      end else if (ev2) begin
         push_req   = 1'b1;
         push_rec   = cand2;
      end

      // A full FIFO rejects the pushed record outright unless the head is
      // leaving this cycle; it does not fall back into the pending slot.
      push_ok = push_req && (!fifo_full || pop);
      ovf_d   = ovf_q || drop || (push_req && !push_ok);
      cnt_d   = (push_ok && (cnt_q != 10'h3FF)) ? cnt_q + 10'd1 : cnt_q;

      state_d = state_q;
      case (state_q)
         RUN:   if (ps == HALT) state_d = DRAIN;
         DRAIN: begin
            if (ps != HALT)
               state_d = RUN;
            else if (fifo_empty && !pend_vld_q && !ev1 && !ev2)
               state_d = DONE;
         end
         DONE:  if (ps != HALT) state_d = RUN;
         default: state_d = RUN;
      endcase
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev1_q    <= '0;
         prev2_q    <= '0;
         resp1_q    <= '0;
         resp2_q    <= '0;
         pend_vld_q <= 1'b0;
         pend_rec_q <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         state_q    <= RUN;
         done_q     <= 1'b0;
      end else begin
         prev1_q    <= prev1_d;
         prev2_q    <= prev2_d;
         resp1_q    <= resp1_d;
         resp2_q    <= resp2_d;
         pend_vld_q <= pend_vld_d;
         pend_rec_q <= pend_rec_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         done_q     <= done_d;
      end
   end

   puf_rec_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .wdata (push_rec),
      .pop   (pop),
      .rdata (rec_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rec_valid = !fifo_empty;
   assign rec_count = cnt_q;
   assign overflow  = ovf_q;
   assign done      = done_q;

endmodule

// File: tb/tb_puf_resp_capture.sv
// -----------------------------------------------------------------------------
// tb_puf_resp_capture
// Directed vectors with hand-computed expected records for puf_resp_capture.
// -----------------------------------------------------------------------------
module tb_puf_resp_capture;
   import puf_pkg::*;

   logic        clk;
   logic        rst_n;
   state_t      ps;
   logic [7:0]  puf1_counter, puf2_counter;
   logic [7:0]  puf1_resp, puf2_resp;
   logic        rec_valid, rec_ready;
   logic [16:0] rec_data;
   logic [9:0]  rec_count;
   logic        overflow, done;

   int   n_chk = 0;
   int   n_err = 0;
   rec_t exp_r;

   puf_resp_capture #(.RESP_W(8), .DEPTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ps           (ps),
      .puf1_counter (puf1_counter),
      .puf2_counter (puf2_counter),
      .puf1_resp    (puf1_resp),
      .puf2_resp    (puf2_resp),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready),
      .rec_data     (rec_data),
      .rec_count    (rec_count),
      .overflow     (overflow),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      puf1_counter = 8'h00;
      puf2_counter = 8'h00;
      rec_ready    = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0; ps = START; rec_ready = 1'b0;
      puf1_counter = 8'h00; puf2_counter = 8'h00;
      puf1_resp = 8'h00; puf2_resp = 8'h00;

      // Reset state
      #3;
      chk("rst_valid", rec_valid, 0);
      chk("rst_data",  rec_data,  0);
      chk("rst_count", rec_count, 0);
      chk("rst_ovf",   overflow,  0);
      chk("rst_done",  done,      0);
      step(); step();
      rst_n = 1'b1;
      step(); step(); step();
      chk("idle_valid", rec_valid, 0);
      chk("idle_count", rec_count, 0);

      // Single PUF1 event: response during arc cycle, counter moves at its edge
      puf1_resp = 8'hA5;
      step();
      puf1_counter = 8'h01;
      chk("single_lat1", rec_valid, 0);
      step();
      chk("single_valid", rec_valid, 1);
      exp_r = '{src: 1'b0, ch: 8'h00, resp: 8'hA5};
      chk("single_data",  rec_data, {15'b0, exp_r});
      chk("single_count", rec_count, 1);
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      chk("single_pop", rec_valid, 0);

      // Set up counters 3/7 (two records, drained), then simultaneous events
      rec_ready = 1'b1;
      puf1_counter = 8'h03; puf2_counter = 8'h07;
      step(); step(); step(); step();
      rec_ready = 1'b0;
      chk("setup_drained", rec_valid, 0);
      chk("setup_count",   rec_count, 3);
      puf1_resp = 8'h11; puf2_resp = 8'h22;
      step();
      puf1_counter = 8'h04; puf2_counter = 8'h08;
      step(); step();
      exp_r = '{src: 1'b0, ch: 8'h03, resp: 8'h11};
      chk("simul_rec1", rec_data, {15'b0, exp_r});
      chk("simul_count", rec_count, 5);
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      exp_r = '{src: 1'b1, ch: 8'h07, resp: 8'h22};
      chk("simul_rec2", rec_data, {15'b0, exp_r});
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;
      chk("simul_empty", rec_valid, 0);
      chk("simul_ovf",   overflow,  0);

      // Full: 17 back-to-back events with the sink stalled
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         puf1_counter = 8'(i);
         step();
      end
      step();
      chk("full_ovf",   overflow,  1);
      chk("full_count", rec_count, 16);
      rec_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk("full_valid", rec_valid, 1);
         chk("full_ch",    rec_data[16:8], j);
         step();
      end
      rec_ready = 1'b0;
      chk("full_empty", rec_valid, 0);

      // Wrap 0xFF -> 0x00 on PUF2
      do_reset();
      rec_ready = 1'b1;
      puf2_counter = 8'hFF;
      step(); step(); step();
      rec_ready = 1'b0;
      chk("wrap_pre_empty", rec_valid, 0);
      puf2_resp = 8'h5C;
      step();
      puf2_counter = 8'h00;
      step();
      exp_r = '{src: 1'b1, ch: 8'hFF, resp: 8'h5C};
      chk("wrap_data",  rec_data,  {15'b0, exp_r});
      chk("wrap_count", rec_count, 2);
      rec_ready = 1'b1;
      step();
      rec_ready = 1'b0;

      // Drain / done
      puf1_counter = 8'h01; step();
      puf1_counter = 8'h02; step();
      puf1_counter = 8'h03; step();
      chk("drain_count", rec_count, 5);
      ps = HALT;
      step();
      chk("drain_done0", done, 0);
      rec_ready = 1'b1;
      step(); step(); step();
      chk("drain_empty", rec_valid, 0);
      chk("drain_done1", done, 0);
      step();
      chk("done_set", done, 1);
      ps = START;
      step();
      chk("done_clr", done, 0);

      // Asynchronous reset mid-cycle with records queued
      rec_ready = 1'b0;
      puf1_counter = 8'h04; step();
      step();
      chk("pre_rst_valid", rec_valid, 1);
      chk("pre_rst_count", rec_count, 6);
      #2;
      rst_n = 1'b0;
      puf1_counter = 8'h00; puf2_counter = 8'h00;
      #1;
      chk("arst_valid", rec_valid, 0);
      chk("arst_count", rec_count, 0);
      chk("arst_data",  rec_data,  0);
      chk("arst_done",  done,      0);
      step();
      rst_n = 1'b1;
      step(); step(); step();
      chk("post_rst_valid", rec_valid, 0);
      chk("post_rst_count", rec_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
